// File: rtl/pio_arb.sv
//==============================================================================
// Module   : pio_arb
// Purpose  : Two-requester round-robin command arbiter for a PIO block, with
//            data/enable shadows, a pin synchronizer and edge interrupts that
//            are built only when PIO_ARB_IRQ_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pio_arb #(
    parameter int dataWidth = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_cmd,
    input  logic [dataWidth-1:0] req0_wdata,
    input  logic [dataWidth-1:0] req0_wmask,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_cmd,
    input  logic [dataWidth-1:0] req1_wdata,
    input  logic [dataWidth-1:0] req1_wmask,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [dataWidth-1:0] rsp_rdata,

    output logic [dataWidth-1:0] pio_wdata,
    output logic [dataWidth-1:0] pio_wenable,
    input  logic [dataWidth-1:0] pio_rdata,

    output logic                 irq0,
    output logic                 irq1
);

    localparam logic [1:0] c_CMD_DATA = 2'b00;
    localparam logic [1:0] c_CMD_OE   = 2'b01;
`ifdef PIO_ARB_IRQ_EN
    localparam logic [1:0] c_CMD_IE   = 2'b10;
    localparam logic [1:0] c_CMD_CLR  = 2'b11;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_rr;
    logic                 r_rsp_id;
    logic [dataWidth-1:0] r_data;
    logic [dataWidth-1:0] r_oe;
    logic [dataWidth-1:0] r_sync1;
    logic [dataWidth-1:0] r_sync2;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    logic [1:0]           w_cmd;
    logic [dataWidth-1:0] w_wdata;
    logic [dataWidth-1:0] w_wmask;

    function automatic logic [dataWidth-1:0] merge(
        input logic [dataWidth-1:0] old_val,
        input logic [dataWidth-1:0] wdata,
        input logic [dataWidth-1:0] wmask
    );
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

    // Grant is combinational so a lone requester is served in the same cycle.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset_n && (r_state == ST_IDLE)) begin
            w_grant0 = req0_valid && (!req1_valid || !r_rr);
            w_grant1 = req1_valid && (!req0_valid ||  r_rr);
        end
        w_accept = w_grant0 || w_grant1;
        w_cmd    = w_grant1 ? req1_cmd   : req0_cmd;
        w_wdata  = w_grant1 ? req1_wdata : req0_wdata;
        w_wmask  = w_grant1 ? req1_wmask : req0_wmask;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_rr     <= 1'b0;
            r_rsp_id <= 1'b0;
            r_data   <= '0;
            r_oe     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_RESP;
                        r_rsp_id <= w_grant1;
                        r_rr     <= !w_grant1;
                        case (w_cmd)
                            c_CMD_DATA: r_data <= merge(r_data, w_wdata, w_wmask);
                            c_CMD_OE:   r_oe   <= merge(r_oe,   w_wdata, w_wmask);
                            default:    ;
                        endcase
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pio_rdata;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_ARB_IRQ_EN
    logic [dataWidth-1:0] r_prev;
    logic [dataWidth-1:0] r_ie;
    logic [dataWidth-1:0] r_pend_rise;
    logic [dataWidth-1:0] r_pend_fall;
    logic [dataWidth-1:0] w_rise;
    logic [dataWidth-1:0] w_fall;
    logic [dataWidth-1:0] w_clr;

    always_comb begin
        w_rise = r_sync2 & ~r_prev;
        w_fall = ~r_sync2 & r_prev;
        w_clr  = '0;
        if (w_accept && (w_cmd == c_CMD_CLR)) begin
            w_clr = w_wdata & w_wmask;
        end
    end

    // A new edge in the same cycle as a clear re-sets the pending bit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_prev      <= '0;
            r_ie        <= '0;
            r_pend_rise <= '0;
            r_pend_fall <= '0;
        end else begin
            r_prev      <= r_sync2;
            r_pend_rise <= (r_pend_rise & ~w_clr) | w_rise;
            r_pend_fall <= (r_pend_fall & ~w_clr) | w_fall;
            if (w_accept && (w_cmd == c_CMD_IE)) begin
                r_ie <= merge(r_ie, w_wdata, w_wmask);
            end
        end
    end

    assign irq0 = |(r_pend_rise & r_ie);
    assign irq1 = |(r_pend_fall & r_ie);
`else
    assign irq0 = 1'b0;
    assign irq1 = 1'b0;
`endif

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_id      = r_rsp_id;
    assign rsp_rdata   = r_sync2;
    assign pio_wdata   = r_data;
    assign pio_wenable = r_oe;

endmodule

`default_nettype wire
